// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: turns a synchronized SPI byte stream (cmd, addr_hi, addr_lo, data...) into single-byte Wishbone cycles; err_o is a sticky timeout/overrun flag, busy_o is high while CS is asserted or a bus cycle is in flight.
module spi_bus_bridge #(
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_strobe_i,
  input  logic [7:0]            spi_data_i,
  output logic [7:0]            spi_data_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [7:0]            wb_data_o,
  input  logic [7:0]            wb_data_i,
  input  logic                  wb_ack_i,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {CMD, ADDR_HI, ADDR_LO, WDATA, RDATA, BUS} state_t;
  state_t                state_q, state_d;
  logic [2:0]            cs_sync_q, cs_sync_d, st_sync_q, st_sync_d;
  logic                  rd_q, rd_d, inc_q, inc_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdat_q, wdat_d, tx_q, tx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cs_off, cs_fall, ev, to, done;
  logic [16:0]           a;
  assign cs_sync_d = {cs_sync_q[1:0], spi_cs_ni};
  assign st_sync_d = {st_sync_q[1:0], spi_strobe_i};
  assign cs_off    = cs_sync_q[1];
  assign cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
  assign ev        = st_sync_q[1] & ~st_sync_q[2] & ~cs_off;
  assign to        = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign done      = wb_ack_i | to;
  assign a         = 17'(addr_q);
  assign wb_cyc_o   = state_q == BUS;
  assign wb_stb_o   = wb_cyc_o;
  assign wb_we_o    = wb_cyc_o & ~rd_q;
  assign wb_addr_o  = addr_q;
  assign wb_data_o  = wdat_q;
  assign spi_data_o = tx_q;
  assign busy_o     = ~cs_off | wb_cyc_o;
  assign err_o      = err_q;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    inc_d   = inc_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    tx_d    = tx_q;
    cnt_d   = '0;
    err_d   = cs_fall ? 1'b0 : err_q;
    case (state_q)
      CMD: begin
        tx_d = '0;
        if (ev) begin
          rd_d    = spi_data_i[7];
          inc_d   = spi_data_i[6];
          addr_d  = ADDR_WIDTH'({spi_data_i[0], 16'h0000});
          state_d = ADDR_HI;
        end
      end
      ADDR_HI: if (ev) begin
        addr_d  = ADDR_WIDTH'({a[16], spi_data_i, a[7:0]});
        state_d = ADDR_LO;
      end
      ADDR_LO: if (ev) begin
        addr_d  = ADDR_WIDTH'({a[16:8], spi_data_i});
        state_d = rd_q ? BUS : WDATA;
      end
      WDATA: if (ev) begin
        wdat_d  = spi_data_i;
        state_d = BUS;
      end
      RDATA: if (ev) state_d = BUS;
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (ev || (to && !wb_ack_i)) err_d = 1'b1;
        if (done) begin
          if (rd_q) tx_d = wb_ack_i ? wb_data_i : 8'hFF;
          if (inc_q) addr_d = addr_q + 1'b1;
          state_d = cs_off ? CMD : (rd_q ? RDATA : WDATA);
        end
      end
      default: state_d = CMD;
    endcase
    if (cs_off && state_q != BUS) state_d = CMD;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= CMD;
      cs_sync_q <= '1;
      st_sync_q <= '0;
      rd_q      <= 1'b0;
      inc_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      tx_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cs_sync_q <= cs_sync_d;
      st_sync_q <= st_sync_d;
      rd_q      <= rd_d;
      inc_q     <= inc_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb_spi_bus_bridge: directed frames against spi_bus_bridge with a byte-memory Wishbone slave.
module tb_spi_bus_bridge;
  logic        clk = 1'b0, rst, cs_n, strobe, ack, ack_en;
  logic [7:0]  sdi, sdo, wdo, wdi;
  logic        cyc, stb, we, busy, err;
  logic [16:0] addr;
  logic [7:0]  mem [0:131071];
  logic [7:0]  log_d [$];
  logic [16:0] log_a [$];
  logic        log_w [$];
  int          n_vec = 0, n_bad = 0, run = 0, last_run = 0;
  always #5 clk = ~clk;
  spi_bus_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .spi_cs_ni(cs_n), .spi_strobe_i(strobe),
    .spi_data_i(sdi), .spi_data_o(sdo), .wb_cyc_o(cyc), .wb_stb_o(stb),
    .wb_we_o(we), .wb_addr_o(addr), .wb_data_o(wdo), .wb_data_i(wdi),
    .wb_ack_i(ack), .busy_o(busy), .err_o(err)
  );
  assign wdi = mem[addr];
  always @(posedge clk) begin
    ack <= ack_en && cyc && stb && !ack;
    if (cyc && stb && ack) begin
      log_a.push_back(addr);
      log_d.push_back(we ? wdo : wdi);
      log_w.push_back(we);
      if (we) mem[addr] <= wdo;
    end
    if (cyc) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run <= 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    sdi = b;
    strobe = 1'b1;
    repeat (4) @(negedge clk);
    strobe = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic set_cs(input logic v);
    cs_n = v;
    repeat (6) @(negedge clk);
  endtask
  task automatic clear_log();
    log_a.delete();
    log_d.delete();
    log_w.delete();
  endtask
  initial begin
    int k;
    rst = 1'b1; cs_n = 1'b1; strobe = 1'b0; sdi = 8'h00; ack = 1'b0; ack_en = 1'b1;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", 32'(wdo), 0);
    chk("rst_sdo", 32'(sdo), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    // auto-increment write frame
    clear_log();
    set_cs(1'b0);
    chk("wr_busy", 32'(busy), 1);
    send_byte(8'h40); send_byte(8'h80); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    set_cs(1'b1);
    chk("wr_count", 32'(log_a.size()), 2);
    chk("wr0_addr", 32'(log_a[0]), 32'h08000);
    chk("wr0_data", 32'(log_d[0]), 32'hAA);
    chk("wr0_we", 32'(log_w[0]), 1);
    chk("wr1_addr", 32'(log_a[1]), 32'h08001);
    chk("wr1_data", 32'(log_d[1]), 32'hBB);
    chk("wr1_we", 32'(log_w[1]), 1);
    chk("wr_mem", 32'(mem[17'h08001]), 32'hBB);
    chk("wr_sdo", 32'(sdo), 0);
    chk("wr_err", 32'(err), 0);
    chk("wr_idle_busy", 32'(busy), 0);
    // auto-increment read wrapping from 0x1FFFF to 0x00000
    mem[17'h1FFFF] = 8'h12; mem[0] = 8'h34; mem[1] = 8'h56;
    clear_log();
    set_cs(1'b0);
    send_byte(8'hC1);
    chk("rd_hdr_sdo", 32'(sdo), 0);
    send_byte(8'hFF); send_byte(8'hFF);
    chk("rd_byte0", 32'(sdo), 32'h12);
    send_byte(8'h00);
    chk("rd_byte1", 32'(sdo), 32'h34);
    chk("rd_wrap_addr", 32'(addr), 1);
    send_byte(8'h00);
    chk("rd_byte2", 32'(sdo), 32'h56);
    chk("rd_addr1", 32'(log_a[1]), 0);
    chk("rd_we", 32'(log_w[0]), 0);
    set_cs(1'b1);
    // read without increment re-reads the same address
    mem[17'h00100] = 8'h77;
    clear_log();
    set_cs(1'b0);
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h00);
    chk("ni_byte0", 32'(sdo), 32'h77);
    mem[17'h00100] = 8'h78; send_byte(8'h00);
    chk("ni_byte1", 32'(sdo), 32'h78);
    mem[17'h00100] = 8'h79; send_byte(8'h00);
    chk("ni_byte2", 32'(sdo), 32'h79);
    mem[17'h00100] = 8'h7A; send_byte(8'h00);
    chk("ni_byte3", 32'(sdo), 32'h7A);
    chk("ni_count", 32'(log_a.size()), 4);
    chk("ni_addr0", 32'(log_a[0]), 32'h00100);
    chk("ni_addr3", 32'(log_a[3]), 32'h00100);
    set_cs(1'b1);
    // ack withheld: timeout
    ack_en = 1'b0;
    set_cs(1'b0);
    send_byte(8'h80); send_byte(8'h00);
    sdi = 8'h10; strobe = 1'b1;
    repeat (4) @(negedge clk);
    strobe = 1'b0;
    k = 0;
    while (!cyc && k < 20) begin @(negedge clk); k++; end
    chk("to_cyc_up", 32'(cyc), 1);
    k = 0;
    while (cyc && k < 400) begin @(negedge clk); k++; end
    chk("to_cyc_down", 32'(cyc), 0);
    @(negedge clk);
    chk("to_len", 32'(last_run), 255);
    chk("to_err", 32'(err), 1);
    chk("to_sdo", 32'(sdo), 32'hFF);
    ack_en = 1'b1;
    set_cs(1'b1);
    chk("to_err_sticky", 32'(err), 1);
    set_cs(1'b0);
    chk("to_err_clear", 32'(err), 0);
    // aborted header then a fresh write frame
    clear_log();
    send_byte(8'h00); send_byte(8'h12);
    set_cs(1'b1);
    set_cs(1'b0);
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h30); send_byte(8'h5A);
    set_cs(1'b1);
    chk("ab_count", 32'(log_a.size()), 1);
    chk("ab_addr", 32'(log_a[0]), 32'h02030);
    chk("ab_data", 32'(log_d[0]), 32'h5A);
    // reset while a read cycle is in flight
    ack_en = 1'b0;
    mem[17'h00040] = 8'h99;
    set_cs(1'b0);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h40);
    chk("mr_cyc_before", 32'(cyc), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_cyc", 32'(cyc), 0);
    chk("mr_stb", 32'(stb), 0);
    chk("mr_addr", 32'(addr), 0);
    chk("mr_sdo", 32'(sdo), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_err", 32'(err), 0);
    rst = 1'b0;
    ack_en = 1'b1;
    clear_log();
    repeat (6) @(negedge clk);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h3C);
    set_cs(1'b1);
    chk("mr_post_count", 32'(log_a.size()), 1);
    chk("mr_post_addr", 32'(log_a[0]), 32'h00005);
    chk("mr_post_data", 32'(log_d[0]), 32'h3C);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
